// File: rtl/jk_seq_driver_if.sv
// jk_seq_driver_if
//   Bundles the sequence request, the J/K drive and the fed-back Q of the
//   JK sequence driver.
//   slave  : the driver side (jk_seq_driver).
//   master : the requester / flip-flop side.
//   Signals:
//     start      request to run a sequence (sampled only while idle)
//     pattern    target Q sequence, bit 0 first
//     len        number of bits to run, 0..WIDTH (larger values clamp)
//     q_fb       Q returned from the driven JK flip-flop
//     j, k       registered excitation toward the flip-flop
//     busy       sequence in progress
//     done       one-cycle pulse at the end of a sequence
//     mismatch   one-cycle pulse when a checked q_fb is wrong
//     err_count  mismatches in the current or last sequence (saturating)
interface jk_seq_driver_if #(
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             q_fb;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [LW-1:0]    err_count;

    modport slave (
        input  start, pattern, len, q_fb,
        output j, k, busy, done, mismatch, err_count
    );

    modport master (
        output start, pattern, len, q_fb,
        input  j, k, busy, done, mismatch, err_count
    );
endinterface

// File: rtl/jk_seq_driver.sv
// jk_seq_driver
//   Drives J/K excitation so that a JK flip-flop walks through a target bit
//   sequence, then checks the flip-flop's Q (q_fb) two edges after each
//   bit is driven.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    jk_seq_driver_if.slave (start/pattern/len/q_fb in,
//            j/k/busy/done/mismatch/err_count out)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; pattern/len latched on the accepting edge
//   RUN   | one pattern bit excited per edge, expected Q pushed to pipeline
//   DRAIN | J/K held at 0 while the last expected bit moves to stage 2
//   FIN   | final check, done pulse, busy drops
module jk_seq_driver #(
    parameter int WIDTH       = 8,
    parameter bit TOGGLE_MODE = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    jk_seq_driver_if.slave  bus
);
    localparam int            LW      = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
    localparam logic [LW-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             model_q, model_d;
    logic             s1_v_q, s1_v_d;
    logic             s1_e_q, s1_e_d;
    logic             s2_v_q, s2_v_d;
    logic             s2_e_q, s2_e_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [LW-1:0]    err_q, err_d;

    logic [LW-1:0]    len_clamped;
    logic             bit_t;
    logic             chk_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            rem_q      <= '0;
            model_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_e_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_e_q     <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            rem_q      <= rem_d;
            model_q    <= model_d;
            s1_v_q     <= s1_v_d;
            s1_e_q     <= s1_e_d;
            s2_v_q     <= s2_v_d;
            s2_e_q     <= s2_e_d;
            j_q        <= j_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        // The latched pattern shifts right each RUN edge, so bit 0 is always
        // the bit being driven.
        bit_t       = pat_q[0];
        chk_fail    = s2_v_q && (bus.q_fb != s2_e_q);

        state_d    = state_q;
        pat_d      = pat_q;
        rem_d      = rem_q;
        model_d    = model_q;
        s1_v_d     = 1'b0;
        s1_e_d     = s1_e_q;
        s2_v_d     = s1_v_q;
        s2_e_d     = s1_e_q;
        j_d        = 1'b0;
        k_d        = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = chk_fail;
        err_d      = (chk_fail && (err_q != ERR_MAX)) ? err_q + LW'(1) : err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    rem_d   = len_clamped;
                    model_d = bus.q_fb;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (len_clamped == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (model_q != bit_t) begin
                    if (TOGGLE_MODE) begin
                        j_d = 1'b1;
                        k_d = 1'b1;
                    end else begin
                        j_d = bit_t;
                        k_d = ~bit_t;
                    end
                end
                // model_q follows the intended Q, never q_fb, so a broken
                // flip-flop keeps mismatching instead of being re-tracked.
                model_d = bit_t;
                s1_v_d  = 1'b1;
                s1_e_d  = bit_t;
                pat_d   = pat_q >> 1;
                rem_d   = rem_q - LW'(1);
                if (rem_q == LW'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing is pushed here, so stage 1 empties on this edge and
                // the last expected bit is checked on the FIN edge, together
                // with the done pulse.
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver
//   Runs a TOGGLE_MODE=0 and a TOGGLE_MODE=1 driver side by side on the same
//   stimulus, each closing the loop through its own JK flip-flop model.
//   Expected J/K, busy, done, mismatch and err_count are derived per cycle
//   from the pattern itself (bit transitions and run length).
module tb_jk_seq_driver;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset     = 1'b1;
    logic             start     = 1'b0;
    logic [WIDTH-1:0] pattern   = '0;
    logic [LW-1:0]    len       = '0;
    logic             fault_en  = 1'b0;
    logic             fault_val = 1'b0;
    logic             ff0_q     = 1'b0;
    logic             ff1_q     = 1'b0;

    int total = 0;
    int bad   = 0;

    jk_seq_driver_if #(.WIDTH(WIDTH)) if0 ();
    jk_seq_driver_if #(.WIDTH(WIDTH)) if1 ();

    assign if0.start   = start;
    assign if0.pattern = pattern;
    assign if0.len     = len;
    assign if0.q_fb    = fault_en ? fault_val : ff0_q;
    assign if1.start   = start;
    assign if1.pattern = pattern;
    assign if1.len     = len;
    assign if1.q_fb    = fault_en ? fault_val : ff1_q;

    jk_seq_driver #(.WIDTH(WIDTH), .TOGGLE_MODE(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    jk_seq_driver #(.WIDTH(WIDTH), .TOGGLE_MODE(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    // Behavioural JK flip-flops closing the loop.
    always @(posedge clk) begin
        ff0_q <= (if0.j && if0.k) ? ~ff0_q : (if0.j ? 1'b1 : (if0.k ? 1'b0 : ff0_q));
        ff1_q <= (if1.j && if1.k) ? ~ff1_q : (if1.j ? 1'b1 : (if1.k ? 1'b0 : ff1_q));
    end

    logic [1:0]    o_j, o_k, o_busy, o_done, o_mis, o_ff;
    logic [LW-1:0] o_err [2];
    assign o_j      = {if1.j, if0.j};
    assign o_k      = {if1.k, if0.k};
    assign o_busy   = {if1.busy, if0.busy};
    assign o_done   = {if1.done, if0.done};
    assign o_mis    = {if1.mismatch, if0.mismatch};
    assign o_ff     = {ff1_q, ff0_q};
    assign o_err[0] = if0.err_count;
    assign o_err[1] = if1.err_count;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete sequence with cycle-by-cycle checks on both drivers.
    // c counts edges after S0 (c=0 is just after S0).
    task automatic do_run(input string name, input logic [WIDTH-1:0] pat,
                          input logic [LW-1:0] ln, input logic fen,
                          input logic fv, input bit noise);
        int   L, done_cyc, errs, i;
        logic q0 [2];
        logic prev, ej, ek, emis, ebusy, edone;
        L        = (int'(ln) > WIDTH) ? WIDTH : int'(ln);
        done_cyc = (L == 0) ? 1 : L + 2;
        errs     = 0;
        @(negedge clk);
        start     = 1'b1;
        pattern   = pat;
        len       = ln;
        fault_en  = fen;
        fault_val = fv;
        q0[0]     = fen ? fv : ff0_q;
        q0[1]     = fen ? fv : ff1_q;
        @(posedge clk);
        for (int c = 0; c <= done_cyc + 1; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            // Post-S0 input noise: start while busy and pattern/len changes.
            if (noise && c < done_cyc) begin
                start   = 1'($urandom);
                pattern = WIDTH'($urandom);
                len     = LW'($urandom);
            end else begin
                start = 1'b0;
            end
            emis = 1'b0;
            if (c >= 3 && c - 3 < L) emis = fen && (fv != pat[c-3]);
            if (emis) errs++;
            ebusy = (c < done_cyc);
            edone = (c == done_cyc);
            for (int d = 0; d < 2; d++) begin
                ej = 1'b0;
                ek = 1'b0;
                if (c >= 1 && c <= L) begin
                    i    = c - 1;
                    prev = (i == 0) ? q0[d] : pat[i-1];
                    if (prev != pat[i]) begin
                        if (d == 1) begin
                            ej = 1'b1;
                            ek = 1'b1;
                        end else begin
                            ej = pat[i];
                            ek = ~pat[i];
                        end
                    end
                end
                total++;
                if (o_j[d] !== ej) begin
                    bad++;
                    $display("FAIL %s j dut%0d cyc%0d: got %b want %b", name, d, c, o_j[d], ej);
                end
                total++;
                if (o_k[d] !== ek) begin
                    bad++;
                    $display("FAIL %s k dut%0d cyc%0d: got %b want %b", name, d, c, o_k[d], ek);
                end
                total++;
                if (o_busy[d] !== ebusy) begin
                    bad++;
                    $display("FAIL %s busy dut%0d cyc%0d: got %b want %b", name, d, c, o_busy[d], ebusy);
                end
                total++;
                if (o_done[d] !== edone) begin
                    bad++;
                    $display("FAIL %s done dut%0d cyc%0d: got %b want %b", name, d, c, o_done[d], edone);
                end
                total++;
                if (o_mis[d] !== emis) begin
                    bad++;
                    $display("FAIL %s mismatch dut%0d cyc%0d: got %b want %b", name, d, c, o_mis[d], emis);
                end
                total++;
                if (o_err[d] !== LW'(errs)) begin
                    bad++;
                    $display("FAIL %s err_count dut%0d cyc%0d: got %0d want %0d", name, d, c, o_err[d], errs);
                end
                if (!fen && c >= 2 && c - 2 < L) begin
                    total++;
                    if (o_ff[d] !== pat[c-2]) begin
                        bad++;
                        $display("FAIL %s ff_q dut%0d cyc%0d: got %b want %b", name, d, c, o_ff[d], pat[c-2]);
                    end
                end
            end
        end
        start    = 1'b0;
        fault_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        pattern = 8'hA5;
        len = LW'(8);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (o_busy[d] !== 1'b0 || o_done[d] !== 1'b0 || o_j[d] !== 1'b0 ||
                o_k[d] !== 1'b0 || o_mis[d] !== 1'b0 || o_err[d] !== '0) begin
                bad++;
                $display("FAIL reset_state dut%0d: got busy=%b done=%b j=%b k=%b mis=%b err=%0d want all 0",
                         d, o_busy[d], o_done[d], o_j[d], o_k[d], o_mis[d], o_err[d]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_normal();
        do_run("normal", 8'b1011_0010, LW'(8), 1'b0, 1'b0, 1'b0);
        do_run("normal_b", 8'b0110_1001, LW'(5), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        do_run("fault_ff", 8'hFF, LW'(4), 1'b1, 1'b0, 1'b0);
        do_run("fault_mix", 8'b1100_1010, LW'(8), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start     = 1'b1;
        pattern   = 8'hFF;
        len       = LW'(8);
        fault_en  = 1'b1;
        fault_val = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (o_err[d] !== LW'(1) || o_busy[d] !== 1'b1) begin
                bad++;
                $display("FAIL midrun_pre dut%0d: got err=%0d busy=%b want err=1 busy=1", d, o_err[d], o_busy[d]);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (o_busy[d] !== 1'b0 || o_j[d] !== 1'b0 || o_k[d] !== 1'b0 ||
                o_err[d] !== '0 || o_done[d] !== 1'b0) begin
                bad++;
                $display("FAIL midrun_reset dut%0d: got busy=%b j=%b k=%b err=%0d done=%b want all 0",
                         d, o_busy[d], o_j[d], o_k[d], o_err[d], o_done[d]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (o_done[d] !== 1'b0 || o_busy[d] !== 1'b0 || o_mis[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL midrun_quiet dut%0d cyc%0d: got done=%b busy=%b mis=%b want 0",
                             d, c, o_done[d], o_busy[d], o_mis[d]);
                end
            end
        end
        fault_en = 1'b0;
        do_run("after_reset", 8'b0101_1100, LW'(8), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start_zero_len();
        do_run("ignored_start", 8'hA5, LW'(8), 1'b0, 1'b0, 1'b1);
        do_run("zero_len", 8'hFF, LW'(0), 1'b0, 1'b0, 1'b0);
        do_run("zero_len_noise", 8'h3C, LW'(0), 1'b1, 1'b0, 1'b1);
        do_run("clamp_len", 8'b1001_0110, LW'(13), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic fen;
        for (int n = 0; n < 30; n++) begin
            fen = ($urandom_range(0, 3) == 0);
            do_run("random", WIDTH'($urandom), LW'($urandom_range(0, (1 << LW) - 1)),
                   fen, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_fault();
        test_reset_mid_run();
        test_ignored_start_zero_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
